// File: rtl/ysyx_23060184_csr_file_if.sv
// ysyx_23060184_csr_file_if
//   Bundles the CSR-file request/response signals between the execute/
//   writeback stage (master) and the CSR file (slave).
//   master drives: csr_en, csr_op, csr_addr, csr_wdata, ecall, mret, pc,
//                  Wvalid, Pready
//   slave drives : rdata, trap_pc, illegal
interface ysyx_23060184_csr_file_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  csr_en;
  logic [1:0]            csr_op;
  logic [11:0]           csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic                  ecall;
  logic                  mret;
  logic [DATA_WIDTH-1:0] pc;
  logic                  Wvalid;
  logic                  Pready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] trap_pc;
  logic                  illegal;

  modport master (
    output csr_en, csr_op, csr_addr, csr_wdata, ecall, mret, pc, Wvalid, Pready,
    input  rdata, trap_pc, illegal
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_wdata, ecall, mret, pc, Wvalid, Pready,
    output rdata, trap_pc, illegal
  );
endinterface

// File: rtl/ysyx_23060184_csr_file.sv
// ysyx_23060184_csr_file
//   Machine-mode CSR file: Zicsr RW/RS/RC, ecall/mret trap entry and exit
//   with MIE/MPIE stacking, read-only ID CSRs and illegal-access detection.
//   Optional macro CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters and
//   their read-only user shadows.
// Ports:
//   clk  - core clock, state updates on posedge
//   rst  - asynchronous active-high reset
//   bus  - slave side of ysyx_23060184_csr_file_if (request in, rdata/
//          trap_pc/illegal out, all outputs combinational)
module ysyx_23060184_csr_file #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] MARCHID      = 32'h015F_DED8,
  parameter logic [DATA_WIDTH-1:0] MCAUSE_ECALL = 32'd11
) (
  input logic                           clk,
  input logic                           rst,
  ysyx_23060184_csr_file_if.slave       bus
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

  logic                  mie_r;
  logic                  mpie_r;
  logic [DATA_WIDTH-1:0] mtvec_r;
  logic [DATA_WIDTH-1:0] mscratch_r;
  logic [DATA_WIDTH-1:0] mepc_r;
  logic [DATA_WIDTH-1:0] mcause_r;
`ifdef CSR_COUNTERS_EN
  logic [2*DATA_WIDTH-1:0] mcycle_r;
  logic [2*DATA_WIDTH-1:0] minstret_r;
`endif

  logic [DATA_WIDTH-1:0] mstatus_s;
  logic [DATA_WIDTH-1:0] old_s;
  logic [DATA_WIDTH-1:0] new_s;
  logic                  hit_s;
  logic                  illegal_s;
  logic                  commit_s;
  logic                  wr_s;

  // MPP is hardwired to M-mode; only MIE and MPIE are real state.
  assign mstatus_s = {{(DATA_WIDTH-13){1'b0}}, 2'b11, 3'b000, mpie_r, 3'b000, mie_r, 3'b000};

  // Address decode: current value of the addressed CSR and whether it exists.
  always_comb begin
    hit_s = 1'b1;
    old_s = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS:   old_s = mstatus_s;
      ADDR_MTVEC:     old_s = mtvec_r;
      ADDR_MSCRATCH:  old_s = mscratch_r;
      ADDR_MEPC:      old_s = mepc_r;
      ADDR_MCAUSE:    old_s = mcause_r;
      ADDR_MVENDORID: old_s = '0;
      ADDR_MARCHID:   old_s = MARCHID;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE,    ADDR_CYCLE:    old_s = mcycle_r[DATA_WIDTH-1:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   old_s = mcycle_r[2*DATA_WIDTH-1:DATA_WIDTH];
      ADDR_MINSTRET,  ADDR_INSTRET:  old_s = minstret_r[DATA_WIDTH-1:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_s = minstret_r[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
      default:        hit_s = 1'b0;
    endcase
  end

  // Zicsr read-modify-write result; op 00 leaves the value untouched.
  always_comb begin
    new_s = old_s;
    case (bus.csr_op)
      2'b01:   new_s = bus.csr_wdata;
      2'b10:   new_s = old_s | bus.csr_wdata;
      2'b11:   new_s = old_s & ~bus.csr_wdata;
      default: new_s = old_s;
    endcase
  end

  // Address space 0xC00-0xFFF is read-only, so any write op there is illegal.
  assign illegal_s = bus.csr_en &&
                     (!hit_s || ((bus.csr_addr[11:10] == 2'b11) && (bus.csr_op != 2'b00)));
  assign commit_s  = bus.Wvalid && bus.Pready;
  // ecall/mret in the same commit take priority and drop the CSR write.
  assign wr_s      = commit_s && bus.csr_en && (bus.csr_op != 2'b00) && !illegal_s &&
                     !bus.ecall && !bus.mret;

  assign bus.rdata   = illegal_s ? '0 : old_s;
  assign bus.illegal = illegal_s;

  // Redirect target: ecall wins over mret.
  always_comb begin
    if (bus.ecall) begin
      bus.trap_pc = mtvec_r;
    end else if (bus.mret) begin
      bus.trap_pc = mepc_r;
    end else begin
      bus.trap_pc = '0;
    end
  end

  // Trap/return stacking and software writes to the machine CSRs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= '0;
      mscratch_r <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
    end else if (commit_s && bus.ecall) begin
      mepc_r   <= bus.pc;
      mcause_r <= MCAUSE_ECALL;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (commit_s && bus.mret) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (wr_s) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: begin
          mie_r  <= new_s[3];
          mpie_r <= new_s[7];
        end
        ADDR_MTVEC:    mtvec_r    <= {new_s[DATA_WIDTH-1:2], 2'b00};
        ADDR_MSCRATCH: mscratch_r <= new_s;
        ADDR_MEPC:     mepc_r     <= {new_s[DATA_WIDTH-1:2], 2'b00};
        ADDR_MCAUSE:   mcause_r   <= new_s;
        default:       mscratch_r <= mscratch_r;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // mcycle: free-running; a software write to one half replaces it and skips the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_r <= '0;
    end else if (wr_s && (bus.csr_addr == ADDR_MCYCLE)) begin
      mcycle_r[DATA_WIDTH-1:0] <= new_s;
    end else if (wr_s && (bus.csr_addr == ADDR_MCYCLEH)) begin
      mcycle_r[2*DATA_WIDTH-1:DATA_WIDTH] <= new_s;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  // minstret: counts commits; a software write to one half replaces it and skips the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minstret_r <= '0;
    end else if (wr_s && (bus.csr_addr == ADDR_MINSTRET)) begin
      minstret_r[DATA_WIDTH-1:0] <= new_s;
    end else if (wr_s && (bus.csr_addr == ADDR_MINSTRETH)) begin
      minstret_r[2*DATA_WIDTH-1:DATA_WIDTH] <= new_s;
    end else if (commit_s) begin
      minstret_r <= minstret_r + 64'd1;
    end
  end
`endif

endmodule
